alu_cmd_driver: RTL and testbench
=================================

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter OP_W, default 3, giving the opcode width in bits.
REQ-003 Port clk_i  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i  in  1  is the synchronous, active-high reset.
REQ-005 Port cmd_valid_i  in  1  means a command is offered.
REQ-006 Port cmd_ready_o  out  1  means the block accepts a command this cycle.
REQ-007 Ports cmd_a_i / cmd_b_i  in  WIDTH  carry the command operands.
REQ-008 Port cmd_op_i  in  OP_W  carries the command opcode.
REQ-009 Port alu_en_o  out  1  is the load enable to the downstream registered ALU.
REQ-010 Ports alu_a_o / alu_b_o  out  WIDTH  and alu_op_o  out  OP_W  carry the operands and opcode to the ALU.
REQ-011 Ports alu_result_i  in  WIDTH  and alu_zero_i  in  1  carry the ALU's registered result and zero flag.
REQ-012 Port rsp_valid_o  out  1  means a response is presented.
REQ-013 Port rsp_ready_i  in  1  means the consumer takes the response.
REQ-014 Ports rsp_result_o  out  WIDTH, rsp_zero_o  out  1  and rsp_op_o  out  OP_W  carry the captured result, zero flag and opcode.

Function
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid_i && cmd_ready_o.
REQ-016 The FSM SHALL have states IDLE, ISSUE, CAPTURE and RESP.
REQ-017 The transitions SHALL be: IDLE->ISSUE on accept; ISSUE->CAPTURE unconditionally; CAPTURE->RESP unconditionally; RESP->IDLE on rsp_ready_i without accept; RESP->ISSUE on rsp_ready_i with accept.
REQ-018 cmd_ready_o SHALL be 1 in IDLE, equal rsp_ready_i in RESP, and be 0 in ISSUE and CAPTURE.
REQ-019 On accept, alu_a_o, alu_b_o and alu_op_o SHALL register the command fields and hold them until the next accept.
REQ-020 alu_en_o SHALL be 1 exactly during the ISSUE cycle and 0 in every other state.
REQ-021 In CAPTURE, alu_result_i and alu_zero_i SHALL be sampled into rsp_result_o and rsp_zero_o at the closing edge, and alu_op_o SHALL be sampled into rsp_op_o.
REQ-022 Latency SHALL be fixed: accept at edge T gives ISSUE in cycle T+1, CAPTURE in T+2, and rsp_valid_o=1 from T+3.
REQ-023 rsp_valid_o SHALL be 1 only in RESP.
REQ-024 rsp_result_o, rsp_zero_o and rsp_op_o SHALL be stable while rsp_valid_o=1 && !rsp_ready_i (backpressure hold).
REQ-025 With rsp_ready_i held high, the block SHALL sustain one command per 3 cycles through back-to-back RESP->ISSUE.
REQ-026 cmd_valid_i SHALL be ignored in ISSUE and CAPTURE; no command is dropped because cmd_ready_o=0 there.

Reset
REQ-027 When rst_i=1 at a rising edge, the FSM SHALL enter IDLE.
REQ-028 When rst_i=1 at a rising edge, all outputs SHALL clear to 0 except cmd_ready_o, which SHALL be 1 from the next cycle.
REQ-029 Reset in ISSUE, CAPTURE or RESP SHALL abandon the transaction with no response emitted, and alu_en_o SHALL be 0 in the cycle after reset.
REQ-030 Reset SHALL take priority over accept and over rsp_ready_i in the same cycle.

Configuration
REQ-031 When macro ALU_CMD_DRIVER_CNT_EN is defined, outputs cnt_done_o (16 bits) and cnt_zero_o (16 bits) SHALL exist.
REQ-032 cnt_done_o SHALL increment on each response handshake; cnt_zero_o SHALL increment on each response handshake with rsp_zero_o=1.
REQ-033 Both counters SHALL saturate at 0xFFFF and SHALL reset to 0.
REQ-034 When the macro is undefined, the counter ports and logic SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-035 The state enum (IDLE, ISSUE, CAPTURE, RESP), the default WIDTH/OP_W constants and the counter width 16 SHALL live in shared package alu_drv_pkg.
REQ-036 The block SHALL be a single module with no sub-module; the FSM and registers SHALL be inline.

Verification
REQ-037 Test 1: reset, then check outputs -> all 0, cmd_ready_o=1 one cycle after reset release.
REQ-038 Test 2: a=0x05, b=0x03, op=0 with a model ALU (op0 = add) -> alu_en_o pulses once in T+1, rsp_valid_o at T+3, rsp_result_o=0x08, rsp_zero_o=0, rsp_op_o=0.
REQ-039 Test 3: a=0x07, b=0x07 with a subtract op -> rsp_result_o=0x00, rsp_zero_o=1.
REQ-040 Test 4: hold rsp_ready_i=0 for 5 cycles -> response fields stable, cmd_ready_o=0, no second alu_en_o pulse; then raise rsp_ready_i with a new command pending -> handshake and accept occur on the same edge.
REQ-041 Test 5: 10 back-to-back commands with rsp_ready_i=1 -> 10 responses in order, 3-cycle spacing, no drops.
REQ-042 Test 6: assert rst_i during CAPTURE -> no rsp_valid_o, and with ALU_CMD_DRIVER_CNT_EN the counters return to 0.

Source files
------------

// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the ALU command driver: FSM state encoding,
// default datapath widths and the response counter width.
package alu_drv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } drv_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OP_W  = 3;
    localparam int CNT_W     = 16;

endpackage

// File: rtl/alu_cmd_driver.sv
// Sequences one command at a time through a downstream registered ALU: issue, capture, respond.
// Optional response counters are compiled in when ALU_CMD_DRIVER_CNT_EN is defined.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OP_W  = DEF_OP_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // a producer holds its payload until then, a consumer may raise ready at any time.
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [WIDTH-1:0]  cmd_a_i,
    input  logic [WIDTH-1:0]  cmd_b_i,
    input  logic [OP_W-1:0]   cmd_op_i,
    output logic              alu_en_o,
    output logic [WIDTH-1:0]  alu_a_o,
    output logic [WIDTH-1:0]  alu_b_o,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [WIDTH-1:0]  alu_result_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_result_o,
    output logic              rsp_zero_o,
    output logic [OP_W-1:0]   rsp_op_o,
`ifdef ALU_CMD_DRIVER_CNT_EN
    output logic [CNT_W-1:0]  cnt_done_o,
    output logic [CNT_W-1:0]  cnt_zero_o,
`endif
    output logic [1:0]        state_dbg_o
);

    drv_state_e state_q;
    drv_state_e state_d;
    logic       accept;
    logic       rsp_hs;

    assign accept      = cmd_valid_i && cmd_ready_o;
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;
    assign state_dbg_o = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        alu_en_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = ISSUE;
            end
            ISSUE: begin
                alu_en_o = 1'b1;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                state_d = RESP;
            end
            RESP: begin
                // The response slot frees on the same edge it is consumed, so a
                // pending command can be taken without an IDLE bubble.
                rsp_valid_o = 1'b1;
                cmd_ready_o = rsp_ready_i;
                if (rsp_ready_i) state_d = cmd_valid_i ? ISSUE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_a_o      <= '0;
            alu_b_o      <= '0;
            alu_op_o     <= '0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            rsp_op_o     <= '0;
        end else begin
            if (accept) begin
                alu_a_o  <= cmd_a_i;
                alu_b_o  <= cmd_b_i;
                alu_op_o <= cmd_op_i;
            end
            // The ALU result registered at the end of ISSUE is valid throughout CAPTURE.
            if (state_q == CAPTURE) begin
                rsp_result_o <= alu_result_i;
                rsp_zero_o   <= alu_zero_i;
                rsp_op_o     <= alu_op_o;
            end
        end
    end

`ifdef ALU_CMD_DRIVER_CNT_EN
    logic [CNT_W-1:0] cnt_done_q;
    logic [CNT_W-1:0] cnt_zero_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_done_q <= '0;
            cnt_zero_q <= '0;
        end else if (rsp_hs) begin
            if (cnt_done_q != '1) cnt_done_q <= cnt_done_q + CNT_W'(1);
            if (rsp_zero_o && (cnt_zero_q != '1)) cnt_zero_q <= cnt_zero_q + CNT_W'(1);
        end
    end

    assign cnt_done_o = cnt_done_q;
    assign cnt_zero_o = cnt_zero_q;
`else
    logic unused_rsp_hs;
    assign unused_rsp_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: model registered ALU, vector table, response scoreboard.
// Also builds with ALU_CMD_DRIVER_CNT_EN defined to check the response counters.
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] cmd_a_i;
    logic [7:0] cmd_b_i;
    logic [2:0] cmd_op_i;
    logic       alu_en_o;
    logic [7:0] alu_a_o;
    logic [7:0] alu_b_o;
    logic [2:0] alu_op_o;
    logic [7:0] alu_result_i = '0;
    logic       alu_zero_i = 1'b0;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_result_o;
    logic       rsp_zero_o;
    logic [2:0] rsp_op_o;
    logic [1:0] state_dbg_o;
`ifdef ALU_CMD_DRIVER_CNT_EN
    logic [15:0] cnt_done_o;
    logic [15:0] cnt_zero_o;
`endif

    alu_cmd_driver #(.WIDTH(8), .OP_W(3)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_a_i      (cmd_a_i),
        .cmd_b_i      (cmd_b_i),
        .cmd_op_i     (cmd_op_i),
        .alu_en_o     (alu_en_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_op_o     (alu_op_o),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_zero_o   (rsp_zero_o),
        .rsp_op_o     (rsp_op_o),
`ifdef ALU_CMD_DRIVER_CNT_EN
        .cnt_done_o   (cnt_done_o),
        .cnt_zero_o   (cnt_zero_o),
`endif
        .state_dbg_o  (state_dbg_o)
    );

    // ---------------- clock / model ALU ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_en_o) begin
            alu_result_i <= alu_f(alu_a_o, alu_b_o, alu_op_o);
            alu_zero_i   <= (alu_f(alu_a_o, alu_b_o, alu_op_o) == 8'h00);
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];
    int en_cnt = 0;
    int hs_cnt = 0;
    int zero_cnt = 0;
    bit spacing_on = 1'b0;
    bit spacing_first = 1'b1;
    int last_hs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] e;
        if (alu_en_o) en_cnt++;
        if (rsp_valid_o && rsp_ready_i) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got 0x%0h, expected no response", {rsp_op_o, rsp_zero_o, rsp_result_o});
            end else begin
                e = exp_q.pop_front();
                chk("rsp_fields", {20'd0, rsp_op_o, rsp_zero_o, rsp_result_o}, {20'd0, e});
                if (e[8]) zero_cnt++;
            end
            if (spacing_on && !spacing_first) chk("rsp_spacing", cyc - last_hs, 3);
            spacing_first = 1'b0;
            last_hs = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    // Called after a rising edge; returns just after the accepting edge.
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic [7:0] res, input logic z);
        bit done;
        done = 1'b0;
        cmd_a_i = a;
        cmd_b_i = b;
        cmd_op_i = op;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                exp_q.push_back({op, z, res});
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        cmd_valid_i = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept, expected accept within 20 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_alu_en"}, alu_en_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_alu_a"}, alu_a_o, 0);
        chk({tag, "_alu_b"}, alu_b_o, 0);
        chk({tag, "_alu_op"}, alu_op_o, 0);
        chk({tag, "_rsp_result"}, rsp_result_o, 0);
        chk({tag, "_rsp_zero"}, rsp_zero_o, 0);
        chk({tag, "_rsp_op"}, rsp_op_o, 0);
`ifdef ALU_CMD_DRIVER_CNT_EN
        chk({tag, "_cnt_done"}, cnt_done_o, 0);
        chk({tag, "_cnt_zero"}, cnt_zero_o, 0);
`endif
    endtask

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       z;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int en_before;
        int hs_before;
        logic [11:0] held;

        vecs[0] = '{a: 8'h05, b: 8'h03, op: 3'd0, res: 8'h08, z: 1'b0};
        vecs[1] = '{a: 8'h07, b: 8'h07, op: 3'd1, res: 8'h00, z: 1'b1};
        vecs[2] = '{a: 8'hF0, b: 8'h0F, op: 3'd2, res: 8'h00, z: 1'b1};
        vecs[3] = '{a: 8'hF0, b: 8'h0F, op: 3'd3, res: 8'hFF, z: 1'b0};
        vecs[4] = '{a: 8'hAA, b: 8'hFF, op: 3'd4, res: 8'h55, z: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'h01, op: 3'd0, res: 8'h00, z: 1'b1};
        vecs[6] = '{a: 8'h00, b: 8'h01, op: 3'd1, res: 8'hFF, z: 1'b0};
        vecs[7] = '{a: 8'h3C, b: 8'h99, op: 3'd5, res: 8'h3C, z: 1'b0};
        vecs[8] = '{a: 8'h12, b: 8'h34, op: 3'd0, res: 8'h46, z: 1'b0};
        vecs[9] = '{a: 8'h80, b: 8'h80, op: 3'd0, res: 8'h00, z: 1'b1};

        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_a_i = '0;
        cmd_b_i = '0;
        cmd_op_i = '0;
        rsp_ready_i = 1'b1;

        // Test 1: reset values and ready after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("t1");
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("t1_cmd_ready", cmd_ready_o, 1);
        chk("t1_state_idle", state_dbg_o, 0);
        @(posedge clk);
        #1;

        // Test 2: add, with cycle-exact latency
        en_before = en_cnt;
        send_cmd(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].res, vecs[0].z);
        @(negedge clk);
        chk("t2_issue_en", alu_en_o, 1);
        chk("t2_alu_a", alu_a_o, 8'h05);
        chk("t2_alu_b", alu_b_o, 8'h03);
        chk("t2_alu_op", alu_op_o, 0);
        chk("t2_issue_ready", cmd_ready_o, 0);
        @(negedge clk);
        chk("t2_capture_en", alu_en_o, 0);
        chk("t2_capture_valid", rsp_valid_o, 0);
        @(negedge clk);
        chk("t2_resp_valid", rsp_valid_o, 1);
        chk("t2_result", rsp_result_o, 8'h08);
        chk("t2_zero", rsp_zero_o, 0);
        chk("t2_op", rsp_op_o, 0);
        #1;
        chk("t2_en_pulses", en_cnt - en_before, 1);
        drain();

        // Test 3: subtract to zero
        @(posedge clk);
        #1;
        send_cmd(vecs[1].a, vecs[1].b, vecs[1].op, vecs[1].res, vecs[1].z);
        repeat (3) @(negedge clk);
        chk("t3_result", rsp_result_o, 8'h00);
        chk("t3_zero", rsp_zero_o, 1);
        chk("t3_op", rsp_op_o, 1);
        drain();

        // Test 4: backpressure hold, then handshake and accept on one edge
        @(posedge clk);
        #1 rsp_ready_i = 1'b0;
        send_cmd(vecs[4].a, vecs[4].b, vecs[4].op, vecs[4].res, vecs[4].z);
        repeat (3) @(negedge clk);
        chk("t4_resp_valid", rsp_valid_o, 1);
        held = {rsp_op_o, rsp_zero_o, rsp_result_o};
        chk("t4_held_value", {20'd0, held}, {20'd0, vecs[4].op, vecs[4].z, vecs[4].res});
        #1;
        en_before = en_cnt;
        cmd_a_i = vecs[8].a;
        cmd_b_i = vecs[8].b;
        cmd_op_i = vecs[8].op;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_fields", {20'd0, rsp_op_o, rsp_zero_o, rsp_result_o}, {20'd0, held});
            chk("t4_hold_valid", rsp_valid_o, 1);
            chk("t4_hold_ready", cmd_ready_o, 0);
        end
        #1;
        chk("t4_no_second_en", en_cnt - en_before, 0);
        @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        hs_before = hs_cnt;
        send_cmd(vecs[8].a, vecs[8].b, vecs[8].op, vecs[8].res, vecs[8].z);
        chk("t4_hs_on_accept_edge", hs_cnt - hs_before, 1);
        @(negedge clk);
        chk("t4_reissue_en", alu_en_o, 1);
        chk("t4_reissue_valid", rsp_valid_o, 0);
        chk("t4_reissue_a", alu_a_o, vecs[8].a);
        drain();

        // Test 5: ten back-to-back commands
        @(posedge clk);
        #1;
        spacing_first = 1'b1;
        spacing_on = 1'b1;
        hs_before = hs_cnt;
        for (int i = 0; i < 10; i++) begin
            send_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].z);
        end
        drain();
        chk("t5_rsp_count", hs_cnt - hs_before, 10);
        spacing_on = 1'b0;

        // Test 6: reset during CAPTURE abandons the transaction
        @(posedge clk);
        #1;
`ifdef ALU_CMD_DRIVER_CNT_EN
        chk("t6_cnt_done_pre", cnt_done_o, hs_cnt);
        chk("t6_cnt_zero_pre", cnt_zero_o, zero_cnt);
`endif
        send_cmd(vecs[3].a, vecs[3].b, vecs[3].op, vecs[3].res, vecs[3].z);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_capture", state_dbg_o, 2);
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        exp_q.delete();
        hs_before = hs_cnt;
        @(negedge clk);
        chk_reset_outputs("t6");
        chk("t6_cmd_ready", cmd_ready_o, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", rsp_valid_o, 0);
        end
        #1;
        chk("t6_no_handshake", hs_cnt - hs_before, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
